// File: rtl/cluster_narrow_id_remap.sv
// Compresses wide cluster AXI IDs into a dense SoC ID space and restores them on R/B.
// Optional stall counters are built only when CLUSTER_ID_REMAP_PERF_EN is defined.
`timescale 1ns/1ps
module cluster_narrow_id_remap #(
  parameter int InIdWidth      = 6,
  parameter int OutIdWidth     = 4,
  parameter int MaxUniqIds     = 16,
  parameter int MaxTxnsPerId   = 4,
  parameter int AxPayloadWidth = 64,
  parameter int RPayloadWidth  = 67
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      slv_ar_valid_i,
  output logic                      slv_ar_ready_o,
  input  logic [InIdWidth-1:0]      slv_ar_id_i,
  input  logic [AxPayloadWidth-1:0] slv_ar_payload_i,
  output logic                      mst_ar_valid_o,
  input  logic                      mst_ar_ready_i,
  output logic [OutIdWidth-1:0]     mst_ar_id_o,
  output logic [AxPayloadWidth-1:0] mst_ar_payload_o,
  input  logic                      slv_aw_valid_i,
  output logic                      slv_aw_ready_o,
  input  logic [InIdWidth-1:0]      slv_aw_id_i,
  input  logic [AxPayloadWidth-1:0] slv_aw_payload_i,
  output logic                      mst_aw_valid_o,
  input  logic                      mst_aw_ready_i,
  output logic [OutIdWidth-1:0]     mst_aw_id_o,
  output logic [AxPayloadWidth-1:0] mst_aw_payload_o,
  input  logic                      mst_r_valid_i,
  output logic                      mst_r_ready_o,
  input  logic [OutIdWidth-1:0]     mst_r_id_i,
  input  logic                      mst_r_last_i,
  input  logic [RPayloadWidth-1:0]  mst_r_payload_i,
  output logic                      slv_r_valid_o,
  input  logic                      slv_r_ready_i,
  output logic [InIdWidth-1:0]      slv_r_id_o,
  output logic                      slv_r_last_o,
  output logic [RPayloadWidth-1:0]  slv_r_payload_o,
  input  logic                      mst_b_valid_i,
  output logic                      mst_b_ready_o,
  input  logic [OutIdWidth-1:0]     mst_b_id_i,
  input  logic [1:0]                mst_b_resp_i,
  output logic                      slv_b_valid_o,
  input  logic                      slv_b_ready_i,
  output logic [InIdWidth-1:0]      slv_b_id_o,
  output logic [1:0]                slv_b_resp_o,
  output logic [31:0]               rd_stall_cnt_o,
  output logic [31:0]               wr_stall_cnt_o
);

  localparam int IdxW = (MaxUniqIds > 1) ? $clog2(MaxUniqIds) : 1;
  localparam int CntW = $clog2(MaxTxnsPerId + 1);
  localparam int NDir = 2;  // index 0 = read table, 1 = write table

  // Handshake semantics: a transfer happens on a cycle where valid and ready are both
  // high at the rising clock edge; valid never depends on ready of the same channel.

  logic [NDir-1:0][MaxUniqIds-1:0] vld_q, vld_d;
  logic [InIdWidth-1:0]            id_q  [NDir][MaxUniqIds];
  logic [InIdWidth-1:0]            id_d  [NDir][MaxUniqIds];
  logic [CntW-1:0]                 cnt_q [NDir][MaxUniqIds];
  logic [CntW-1:0]                 cnt_d [NDir][MaxUniqIds];

  logic [NDir-1:0]                 req_valid, dn_ready, can_map, req_fire, rsp_fire;
  logic [NDir-1:0]                 hit, free_found;
  logic [InIdWidth-1:0]            req_id    [NDir];
  logic [IdxW-1:0]                 hit_idx   [NDir];
  logic [IdxW-1:0]                 free_idx  [NDir];
  logic [IdxW-1:0]                 alloc_idx [NDir];
  logic [IdxW-1:0]                 rsp_idx   [NDir];
  logic [NDir-1:0][MaxUniqIds-1:0] inc_v, dec_v;

  assign req_valid  = {slv_aw_valid_i, slv_ar_valid_i};
  assign dn_ready   = {mst_aw_ready_i, mst_ar_ready_i};
  assign req_id[0]  = slv_ar_id_i;
  assign req_id[1]  = slv_aw_id_i;
  assign rsp_idx[0] = mst_r_id_i[IdxW-1:0];
  assign rsp_idx[1] = mst_b_id_i[IdxW-1:0];
  assign req_fire   = req_valid & dn_ready & can_map;
  assign rsp_fire   = {mst_b_valid_i & slv_b_ready_i,
                       mst_r_valid_i & slv_r_ready_i & mst_r_last_i};

  // Lookup uses only registered state, so an entry freed this cycle is not reusable until next.
  always_comb begin
    hit        = '0;
    free_found = '0;
    can_map    = '0;
    for (int d = 0; d < NDir; d++) begin
      hit_idx[d]   = '0;
      free_idx[d]  = '0;
      alloc_idx[d] = '0;
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (vld_q[d][i] && (id_q[d][i] == req_id[d])) begin
          hit[d]     = 1'b1;
          hit_idx[d] = IdxW'(i);
        end
      end
      for (int i = MaxUniqIds - 1; i >= 0; i--) begin
        if (!vld_q[d][i]) begin
          free_found[d] = 1'b1;
          free_idx[d]   = IdxW'(i);
        end
      end
      can_map[d]   = hit[d] ? (cnt_q[d][hit_idx[d]] < CntW'(MaxTxnsPerId)) : free_found[d];
      alloc_idx[d] = hit[d] ? hit_idx[d] : free_idx[d];
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int d = 0; d < NDir; d++) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        inc_v[d][i] = req_fire[d] && (alloc_idx[d] == IdxW'(i));
        dec_v[d][i] = rsp_fire[d] && vld_q[d][i] && (rsp_idx[d] == IdxW'(i));
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    cnt_d = cnt_q;
    for (int d = 0; d < NDir; d++) begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        if (inc_v[d][i] && !dec_v[d][i]) begin
          vld_d[d][i] = 1'b1;
          id_d[d][i]  = req_id[d];
          cnt_d[d][i] = cnt_q[d][i] + CntW'(1);
        end else if (dec_v[d][i] && !inc_v[d][i]) begin
          cnt_d[d][i] = cnt_q[d][i] - CntW'(1);
          if (cnt_q[d][i] == CntW'(1)) vld_d[d][i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int d = 0; d < NDir; d++) begin
        for (int i = 0; i < MaxUniqIds; i++) begin
          id_q[d][i]  <= '0;
          cnt_q[d][i] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
      cnt_q <= cnt_d;
    end
  end

  assign mst_ar_valid_o   = slv_ar_valid_i & can_map[0];
  assign slv_ar_ready_o   = mst_ar_ready_i & can_map[0];
  assign mst_ar_id_o      = OutIdWidth'(alloc_idx[0]);
  assign mst_ar_payload_o = slv_ar_payload_i;
  assign mst_aw_valid_o   = slv_aw_valid_i & can_map[1];
  assign slv_aw_ready_o   = mst_aw_ready_i & can_map[1];
  assign mst_aw_id_o      = OutIdWidth'(alloc_idx[1]);
  assign mst_aw_payload_o = slv_aw_payload_i;

  assign slv_r_valid_o    = mst_r_valid_i;
  assign mst_r_ready_o    = slv_r_ready_i;
  assign slv_r_id_o       = id_q[0][rsp_idx[0]];
  assign slv_r_last_o     = mst_r_last_i;
  assign slv_r_payload_o  = mst_r_payload_i;
  assign slv_b_valid_o    = mst_b_valid_i;
  assign mst_b_ready_o    = slv_b_ready_i;
  assign slv_b_id_o       = id_q[1][rsp_idx[1]];
  assign slv_b_resp_o     = mst_b_resp_i;

`ifdef CLUSTER_ID_REMAP_PERF_EN
  logic [NDir-1:0] stall;
  logic [31:0]     stall_cnt_q [NDir];

  assign stall = req_valid & ~can_map;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NDir; d++) stall_cnt_q[d] <= '0;
    end else begin
      for (int d = 0; d < NDir; d++) begin
        if (stall[d] && (stall_cnt_q[d] != '1)) stall_cnt_q[d] <= stall_cnt_q[d] + 32'd1;
      end
    end
  end

  assign rd_stall_cnt_o = stall_cnt_q[0];
  assign wr_stall_cnt_o = stall_cnt_q[1];
`else
  assign rd_stall_cnt_o = '0;
  assign wr_stall_cnt_o = '0;
`endif

  // A response may only target an entry that holds outstanding transactions.
  for (genvar gd = 0; gd < NDir; gd++) begin : g_rsp_chk
    rsp_hits_valid_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rsp_fire[gd] |-> vld_q[gd][rsp_idx[gd]]);
  end

endmodule

// File: tb/tb_cluster_narrow_id_remap.sv
// Directed and randomized bench for cluster_narrow_id_remap against a table-level model.
// Stall counter expectations follow CLUSTER_ID_REMAP_PERF_EN.
`timescale 1ns/1ps
module tb_cluster_narrow_id_remap;
  localparam int InW  = 6;
  localparam int OutW = 4;
  localparam int N    = 16;
  localparam int MaxT = 4;
  localparam int AxW  = 64;
  localparam int RW   = 67;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            ar_valid, ar_ready_o, mst_ar_valid, mst_ar_ready;
  logic [InW-1:0]  ar_id;
  logic [AxW-1:0]  ar_payload, mst_ar_payload;
  logic [OutW-1:0] mst_ar_id;
  logic            aw_valid, aw_ready_o, mst_aw_valid, mst_aw_ready;
  logic [InW-1:0]  aw_id;
  logic [AxW-1:0]  aw_payload, mst_aw_payload;
  logic [OutW-1:0] mst_aw_id;
  logic            r_valid, mst_r_ready, r_last, slv_r_valid, slv_r_ready, slv_r_last;
  logic [OutW-1:0] r_id;
  logic [RW-1:0]   r_payload, slv_r_payload;
  logic [InW-1:0]  slv_r_id;
  logic            b_valid, mst_b_ready, slv_b_valid, slv_b_ready;
  logic [OutW-1:0] b_id;
  logic [1:0]      b_resp, slv_b_resp;
  logic [InW-1:0]  slv_b_id;
  logic [31:0]     rd_stall_cnt, wr_stall_cnt;

  cluster_narrow_id_remap dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready_o), .slv_ar_id_i(ar_id),
    .slv_ar_payload_i(ar_payload), .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
    .mst_ar_id_o(mst_ar_id), .mst_ar_payload_o(mst_ar_payload),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready_o), .slv_aw_id_i(aw_id),
    .slv_aw_payload_i(aw_payload), .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
    .mst_aw_id_o(mst_aw_id), .mst_aw_payload_o(mst_aw_payload),
    .mst_r_valid_i(r_valid), .mst_r_ready_o(mst_r_ready), .mst_r_id_i(r_id),
    .mst_r_last_i(r_last), .mst_r_payload_i(r_payload),
    .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready), .slv_r_id_o(slv_r_id),
    .slv_r_last_o(slv_r_last), .slv_r_payload_o(slv_r_payload),
    .mst_b_valid_i(b_valid), .mst_b_ready_o(mst_b_ready), .mst_b_id_i(b_id),
    .mst_b_resp_i(b_resp), .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready),
    .slv_b_id_o(slv_b_id), .slv_b_resp_o(slv_b_resp),
    .rd_stall_cnt_o(rd_stall_cnt), .wr_stall_cnt_o(wr_stall_cnt)
  );

  // ---------------- reference model ----------------
  int             vectors = 0;
  int             miscompares = 0;
  logic [InW-1:0] exp_q[$];
  logic [InW-1:0] exp_b_q[$];
  int             m_cnt [2][N];
  logic [InW-1:0] m_id  [2][N];
  longint         m_stall [2];

  function automatic int m_hit(input int d, input logic [InW-1:0] id);
    for (int s = 0; s < N; s++) if (m_cnt[d][s] > 0 && m_id[d][s] == id) return s;
    return -1;
  endfunction

  function automatic int m_free(input int d);
    for (int s = 0; s < N; s++) if (m_cnt[d][s] == 0) return s;
    return -1;
  endfunction

  function automatic bit m_can(input int d, input logic [InW-1:0] id);
    int h = m_hit(d, id);
    if (h >= 0) return m_cnt[d][h] < MaxT;
    return m_free(d) >= 0;
  endfunction

  function automatic int m_slot(input int d, input logic [InW-1:0] id);
    int h = m_hit(d, id);
    return (h >= 0) ? h : m_free(d);
  endfunction

  function automatic int pick_slot(input int d);
    int list[$];
    for (int s = 0; s < N; s++) if (m_cnt[d][s] > 0) list.push_back(s);
    if (list.size() == 0) return -1;
    return list[$urandom_range(0, list.size() - 1)];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_stall[d] = 0;
      for (int s = 0; s < N; s++) begin
        m_cnt[d][s] = 0;
        m_id[d][s]  = '0;
      end
    end
    exp_q.delete();
    exp_b_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit can_r, can_w;
    #1;
    can_r = m_can(0, ar_id);
    can_w = m_can(1, aw_id);
    chk("ar_valid", mst_ar_valid, ar_valid & can_r);
    chk("ar_ready", ar_ready_o, mst_ar_ready & can_r);
    chk("ar_payload", mst_ar_payload, ar_payload);
    if (ar_valid && can_r) chk("ar_id", mst_ar_id, m_slot(0, ar_id));
    chk("aw_valid", mst_aw_valid, aw_valid & can_w);
    chk("aw_ready", aw_ready_o, mst_aw_ready & can_w);
    chk("aw_payload", mst_aw_payload, aw_payload);
    if (aw_valid && can_w) chk("aw_id", mst_aw_id, m_slot(1, aw_id));
    chk("r_valid", slv_r_valid, r_valid);
    chk("r_ready", mst_r_ready, slv_r_ready);
    if (r_valid && exp_q.size() > 0) begin
      chk("r_id", slv_r_id, exp_q.pop_front());
      chk("r_last", slv_r_last, r_last);
      chk("r_payload", slv_r_payload, r_payload);
    end
    chk("b_valid", slv_b_valid, b_valid);
    chk("b_ready", mst_b_ready, slv_b_ready);
    if (b_valid && exp_b_q.size() > 0) begin
      chk("b_id", slv_b_id, exp_b_q.pop_front());
      chk("b_resp", slv_b_resp, b_resp);
    end
`ifdef CLUSTER_ID_REMAP_PERF_EN
    chk("rd_stall_cnt", rd_stall_cnt, m_stall[0]);
    chk("wr_stall_cnt", wr_stall_cnt, m_stall[1]);
`else
    chk("rd_stall_cnt", rd_stall_cnt, 0);
    chk("wr_stall_cnt", wr_stall_cnt, 0);
`endif
  endtask

  // Advance one clock, applying this cycle's handshakes to the model.
  task automatic tick();
    bit can_r  = m_can(0, ar_id);
    bit can_w  = m_can(1, aw_id);
    bit ar_f   = ar_valid && mst_ar_ready && can_r;
    bit aw_f   = aw_valid && mst_aw_ready && can_w;
    int ar_s   = m_slot(0, ar_id);
    int aw_s   = m_slot(1, aw_id);
    bit r_f    = r_valid && slv_r_ready && r_last;
    bit b_f    = b_valid && slv_b_ready;
    @(posedge clk);
    if (r_f) m_cnt[0][r_id]--;
    if (b_f) m_cnt[1][b_id]--;
    if (ar_f) begin m_cnt[0][ar_s]++; m_id[0][ar_s] = ar_id; end
    if (aw_f) begin m_cnt[1][aw_s]++; m_id[1][aw_s] = aw_id; end
    if (ar_valid && !can_r && m_stall[0] < 64'hFFFF_FFFF) m_stall[0]++;
    if (aw_valid && !can_w && m_stall[1] < 64'hFFFF_FFFF) m_stall[1]++;
    #1;
    r_valid = 1'b0;
    b_valid = 1'b0;
    exp_q.delete();
    exp_b_q.delete();
    @(negedge clk);
  endtask

  task automatic step();
    check_outputs();
    tick();
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    ar_valid = 0; ar_id = '0; ar_payload = '0; mst_ar_ready = 1;
    aw_valid = 0; aw_id = '0; aw_payload = '0; mst_aw_ready = 1;
    r_valid = 0; r_id = '0; r_last = 0; r_payload = '0; slv_r_ready = 1;
    b_valid = 0; b_id = '0; b_resp = '0; slv_b_ready = 1;
  endtask

  task automatic drive_ar(input bit v, input logic [InW-1:0] id);
    ar_valid = v; ar_id = id; ar_payload = {$urandom, $urandom};
  endtask

  task automatic drive_aw(input bit v, input logic [InW-1:0] id);
    aw_valid = v; aw_id = id; aw_payload = {$urandom, $urandom};
  endtask

  task automatic drive_r(input int idx, input bit last);
    r_valid = 1; r_id = OutW'(idx); r_last = last;
    r_payload = {$urandom, $urandom, 3'($urandom)};
    exp_q.push_back(m_id[0][idx]);
  endtask

  task automatic drive_b(input int idx, input logic [1:0] resp);
    b_valid = 1; b_id = OutW'(idx); b_resp = resp;
    exp_b_q.push_back(m_id[1][idx]);
  endtask

  task automatic drain_all();
    drive_ar(0, '0);
    drive_aw(0, '0);
    slv_r_ready = 1;
    slv_b_ready = 1;
    for (int s = 0; s < N; s++) begin
      while (m_cnt[0][s] > 0) begin drive_r(s, 1); step(); end
      while (m_cnt[1][s] > 0) begin drive_b(s, 2'b00); step(); end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    rst_n = 0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_outputs();
    chk("rst_rd_stall", rd_stall_cnt, 0);
    tick();

    // single read
    drive_ar(1, 6'h2A);
    check_outputs(); chk("t1_ar_id", mst_ar_id, 0); tick();
    drive_ar(0, '0); drive_r(0, 1);
    check_outputs(); chk("t1_r_id", slv_r_id, 6'h2A); tick();

    // same-ID burst up to the per-entry limit
    for (int k = 0; k < 4; k++) begin
      drive_ar(1, 6'h05);
      check_outputs(); chk("t2_ar_id", mst_ar_id, 0); chk("t2_ar_rdy", ar_ready_o, 1); tick();
    end
    for (int k = 0; k < 2; k++) begin
      check_outputs(); chk("t2_stall", ar_ready_o, 0); chk("t2_stall_v", mst_ar_valid, 0); tick();
    end
    drive_r(0, 1);
    check_outputs(); chk("t2_stall_r", ar_ready_o, 0); tick();
    check_outputs(); chk("t2_issue", ar_ready_o, 1); chk("t2_issue_id", mst_ar_id, 0); tick();
    drive_ar(0, '0);
    drive_r(0, 1); step();
    drive_r(0, 1); step();

    // simultaneous request and completion on entry 0 (cnt 2)
    drive_ar(1, 6'h05); drive_r(0, 1);
    check_outputs(); chk("t4_rdy", ar_ready_o, 1); chk("t4_id", mst_ar_id, 0); tick();
    drive_ar(0, '0); drive_r(0, 1); step();
    drive_ar(1, 6'h33);
    check_outputs(); chk("t4_still_valid", mst_ar_id, 1); tick();
    drive_ar(0, '0); drive_r(0, 1); step();
    drive_ar(1, 6'h34);
    check_outputs(); chk("t4_freed", mst_ar_id, 0); tick();
    drain_all();

    // table full
    for (int i = 0; i < N; i++) begin
      drive_ar(1, InW'(32 + i));
      check_outputs(); chk("t3_fill", mst_ar_id, i); tick();
    end
    drive_ar(1, 6'h3E);
    for (int k = 0; k < 3; k++) begin
      check_outputs(); chk("t3_full", ar_ready_o, 0); chk("t3_full_v", mst_ar_valid, 0); tick();
    end
`ifdef CLUSTER_ID_REMAP_PERF_EN
    chk("t3_stall_cnt", rd_stall_cnt, 32'd6);
`else
    chk("t3_stall_cnt", rd_stall_cnt, 32'd0);
`endif
    drive_r(7, 1);
    check_outputs(); chk("t3_free_same", ar_ready_o, 0); tick();
    check_outputs(); chk("t3_remap_rdy", ar_ready_o, 1); chk("t3_remap_id", mst_ar_id, 7); tick();
    drive_ar(0, '0);

    // write side independent of a full read table
    drive_aw(1, 6'h11);
    check_outputs(); chk("t5_aw_valid", mst_aw_valid, 1); chk("t5_aw_id", mst_aw_id, 0); tick();
    drive_aw(0, '0); drive_b(0, 2'b10);
    check_outputs(); chk("t5_b_id", slv_b_id, 6'h11); chk("t5_b_resp", slv_b_resp, 2'b10); tick();

    // reset mid-traffic with three read entries live
    drain_all();
    for (int i = 0; i < 3; i++) begin drive_ar(1, InW'(8 + i)); step(); end
    drive_ar(0, '0);
    rst_n = 0;
    #2;
    model_reset();
    rst_n = 1;
    drive_ar(1, 6'h3F);
    check_outputs(); chk("t6_id", mst_ar_id, 0); chk("t6_stall", rd_stall_cnt, 0); tick();
    drive_ar(0, '0);

    // randomized traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drive_ar(1'($urandom_range(0, 1)), InW'($urandom_range(0, 19)));
      mst_ar_ready = ($urandom_range(0, 3) != 0);
      drive_aw(1'($urandom_range(0, 1)), InW'($urandom_range(0, 19)));
      mst_aw_ready = ($urandom_range(0, 3) != 0);
      slv_r_ready = ($urandom_range(0, 3) != 0);
      slv_b_ready = ($urandom_range(0, 3) != 0);
      s = pick_slot(0);
      if (s >= 0 && $urandom_range(0, 1) == 1) drive_r(s, 1'($urandom_range(0, 1)));
      s = pick_slot(1);
      if (s >= 0 && $urandom_range(0, 1) == 1) drive_b(s, 2'($urandom_range(0, 3)));
      step();
    end
    drain_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
